// File: rtl/lr_shift_arbiter_pkg.sv
// Shared types and helpers for the time-shared left/right shifter.
package lr_shift_arbiter_pkg;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  localparam int unsigned DIR_W = 1;
  localparam int unsigned SRC_W = 1;
  localparam int unsigned NUM_REQ = 2;

  // Ceiling log2, for sizing shift-amount fields.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of the shift-amount field for a given data width.
  function automatic int unsigned shift_w(input int unsigned width);
    return clog2(width);
  endfunction

endpackage

// File: rtl/lr_shift_arbiter_if.sv
// Request channels, output channel and grant counters of lr_shift_arbiter.
interface lr_shift_arbiter_if
  import lr_shift_arbiter_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned cntWidth = 16
) ();

  localparam int unsigned shw = shift_w(width);

  logic                req0Valid;
  logic                req0Ready;
  logic [width-1:0]    req0Bits;
  logic [shw-1:0]      req0Shift;
  logic [DIR_W-1:0]    req0Dir;

  logic                req1Valid;
  logic                req1Ready;
  logic [width-1:0]    req1Bits;
  logic [shw-1:0]      req1Shift;
  logic [DIR_W-1:0]    req1Dir;

  logic                oValid;
  logic                oReady;
  logic [width-1:0]    oBits;
  logic [SRC_W-1:0]    oSrc;

  logic [cntWidth-1:0] grantCnt0;
  logic [cntWidth-1:0] grantCnt1;

  // Environment side: drives requests and output ready.
  modport master (
    output req0Valid, req0Bits, req0Shift, req0Dir,
    output req1Valid, req1Bits, req1Shift, req1Dir,
    output oReady,
    input  req0Ready, req1Ready,
    input  oValid, oBits, oSrc, grantCnt0, grantCnt1
  );

  // Arbiter side.
  modport slave (
    input  req0Valid, req0Bits, req0Shift, req0Dir,
    input  req1Valid, req1Bits, req1Shift, req1Dir,
    input  oReady,
    output req0Ready, req1Ready,
    output oValid, oBits, oSrc, grantCnt0, grantCnt1
  );

endinterface

// File: rtl/lr_shift_arbiter_rr.sv
// Two-way round-robin arbiter: combinational grant plus the priority register.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] ready,
  output logic       grant,
  output logic       prio
);

  // Lone requester wins; on contention the favoured one wins.
  always_comb begin
    grant = 1'b0;
    unique case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = prio;
      default: grant = 1'b0;
    endcase
    ready    = '0;
    ready[0] = enable && valid[0] && (grant == 1'b0);
    ready[1] = enable && valid[1] && (grant == 1'b1);
  end

  // Favour the other requester after every accept; withdrawals leave prio alone.
  always_ff @(posedge clk) begin
    if (rst)         prio <= 1'b0;
    else if (|ready) prio <= ~grant;
  end

endmodule

// File: rtl/lr_shift_arbiter_shifter.sv
// Combinational logical left/right shifter, zero-filling in both directions.
module lr_shift_arbiter_shifter
  import lr_shift_arbiter_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0]         bits,
  input  logic [shift_w(width)-1:0] shift,
  input  shift_dir_e               dir,
  output logic [width-1:0]         result
);

  // Select shift direction.
  always_comb begin
    result = '0;
    if (dir == SHIFT_RIGHT) result = bits >> shift;
    else                    result = bits << shift;
  end

endmodule

// File: rtl/lr_shift_arbiter.sv
// Time-shares one left/right shifter between two requesters with a
// single-entry registered output stage and per-requester grant counters.
module lr_shift_arbiter
  import lr_shift_arbiter_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned cntWidth = 16
) (
  input  logic              clk,
  input  logic              rst,
  lr_shift_arbiter_if.slave bus
);

  localparam int unsigned shw = shift_w(width);

  logic                o_valid;
  logic [width-1:0]    o_bits;
  logic                o_src;
  logic [cntWidth-1:0] cnt0;
  logic [cntWidth-1:0] cnt1;

  logic                can_accept;
  logic                enable;
  logic [1:0]          ready;
  logic                grant;
  logic                prio;
  logic [width-1:0]    sel_bits;
  logic [shw-1:0]      sel_shift;
  shift_dir_e          sel_dir;
  logic [width-1:0]    shifted;

  // Reset gates the readies so nothing is acknowledged while it is asserted.
  always_comb begin
    can_accept = !o_valid || bus.oReady;
    enable     = can_accept && !rst;
  end

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.req1Valid, bus.req0Valid}),
    .enable (enable),
    .ready  (ready),
    .grant  (grant),
    .prio   (prio)
  );

  // Steer the granted request into the shared shifter.
  always_comb begin
    sel_bits  = grant ? bus.req1Bits  : bus.req0Bits;
    sel_shift = grant ? bus.req1Shift : bus.req0Shift;
    sel_dir   = shift_dir_e'(grant ? bus.req1Dir : bus.req0Dir);
  end

  lr_shift_arbiter_shifter #(.width(width)) u_shift (
    .bits   (sel_bits),
    .shift  (sel_shift),
    .dir    (sel_dir),
    .result (shifted)
  );

  // Output stage: load on accept (replacing a draining entry), else clear on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_bits  <= '0;
      o_src   <= 1'b0;
    end else if (|ready) begin
      o_valid <= 1'b1;
      o_bits  <= shifted;
      o_src   <= grant;
    end else if (bus.oReady) begin
      o_valid <= 1'b0;
    end
  end

  // Saturating per-requester accept counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (ready[0] && (cnt0 != '1)) cnt0 <= cnt0 + cntWidth'(1);
      if (ready[1] && (cnt1 != '1)) cnt1 <= cnt1 + cntWidth'(1);
    end
  end

  assign bus.req0Ready = ready[0];
  assign bus.req1Ready = ready[1];
  assign bus.oValid    = o_valid;
  assign bus.oBits     = o_bits;
  assign bus.oSrc      = o_src;
  assign bus.grantCnt0 = cnt0;
  assign bus.grantCnt1 = cnt1;

endmodule

// File: tb/tb_lr_shift_arbiter.sv
// Directed bench for lr_shift_arbiter: reset, contention, single requester,
// drain, backpressure, mid-operation reset and counter saturation.
module tb_lr_shift_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  lr_shift_arbiter_if #(.width(8), .cntWidth(16)) bus ();
  lr_shift_arbiter_if #(.width(8), .cntWidth(2))  sat ();

  lr_shift_arbiter #(.width(8), .cntWidth(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lr_shift_arbiter #(.width(8), .cntWidth(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic v, input logic [7:0] b, input logic [2:0] s, input logic d);
    bus.req0Valid = v; bus.req0Bits = b; bus.req0Shift = s; bus.req0Dir = d;
  endtask

  task automatic req1(input logic v, input logic [7:0] b, input logic [2:0] s, input logic d);
    bus.req1Valid = v; bus.req1Bits = b; bus.req1Shift = s; bus.req1Dir = d;
  endtask

  task automatic out_check(input string tag, input logic v, input logic [7:0] b, input logic s);
    check({tag, "_valid"}, 32'(bus.oValid), 32'(v));
    check({tag, "_bits"},  32'(bus.oBits),  32'(b));
    check({tag, "_src"},   32'(bus.oSrc),   32'(s));
  endtask

  task automatic ready_check(input string tag, input logic r0, input logic r1);
    check({tag, "_rdy0"}, 32'(bus.req0Ready), 32'(r0));
    check({tag, "_rdy1"}, 32'(bus.req1Ready), 32'(r1));
  endtask

  initial begin
    bus.oReady = 1'b0;
    req0(1'b1, 8'h81, 3'd1, 1'b0);
    req1(1'b1, 8'h55, 3'd0, 1'b1);
    sat.oReady = 1'b1;
    sat.req0Valid = 1'b0; sat.req0Bits = 8'h00; sat.req0Shift = 3'd0; sat.req0Dir = 1'b0;
    sat.req1Valid = 1'b0; sat.req1Bits = 8'h03; sat.req1Shift = 3'd1; sat.req1Dir = 1'b0;

    // Reset held two cycles with both requesters valid.
    tick(); #1;
    ready_check("rst_c1", 1'b0, 1'b0);
    tick(); #1;
    ready_check("rst_c2", 1'b0, 1'b0);
    out_check("rst", 1'b0, 8'h00, 1'b0);
    check("rst_cnt0", 32'(bus.grantCnt0), 32'd0);
    check("rst_cnt1", 32'(bus.grantCnt1), 32'd0);

    // Release: requester 0 is favoured first, then strict alternation.
    rst = 1'b0;
    bus.oReady = 1'b1;
    #1;
    ready_check("first_grant", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) out_check("contend", 1'b1, 8'h02, 1'b0);
      else            out_check("contend", 1'b1, 8'h55, 1'b1);
    end
    check("contend_cnt0", 32'(bus.grantCnt0), 32'd2);
    check("contend_cnt1", 32'(bus.grantCnt1), 32'd2);

    // Single requester, right shift by the maximum amount.
    req1(1'b0, 8'h55, 3'd0, 1'b1);
    req0(1'b1, 8'h80, 3'd7, 1'b1);
    tick();
    out_check("single_r7", 1'b1, 8'h01, 1'b0);
    check("single_cnt0", 32'(bus.grantCnt0), 32'd3);

    // Drain with no refill: valid drops, data holds.
    req0(1'b0, 8'h80, 3'd7, 1'b1);
    tick();
    out_check("drain", 1'b0, 8'h01, 1'b0);

    // Load 0x0F (shift 0 passthrough) into an empty stage while oReady is low.
    req0(1'b1, 8'h0F, 3'd0, 1'b0);
    bus.oReady = 1'b0;
    tick();
    out_check("load0f", 1'b1, 8'h0F, 1'b0);
    check("load0f_cnt0", 32'(bus.grantCnt0), 32'd4);

    // Backpressure with both requesting: everything holds, no readies.
    req0(1'b1, 8'hAA, 3'd1, 1'b0);
    req1(1'b1, 8'h3C, 3'd2, 1'b0);
    #1;
    ready_check("bp_pre", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      out_check("bp_hold", 1'b1, 8'h0F, 1'b0);
      ready_check("bp_hold", 1'b0, 1'b0);
    end
    check("bp_cnt0", 32'(bus.grantCnt0), 32'd4);
    check("bp_cnt1", 32'(bus.grantCnt1), 32'd2);

    // Release: requester 1 is favoured (last grant was 0); no bubble.
    bus.oReady = 1'b1;
    #1;
    ready_check("bp_release", 1'b0, 1'b1);
    tick();
    out_check("no_bubble", 1'b1, 8'hF0, 1'b1);
    check("no_bubble_cnt1", 32'(bus.grantCnt1), 32'd3);

    // Requester 0 alone (prio now favours 0 anyway), leaves prio=1.
    req1(1'b0, 8'h3C, 3'd2, 1'b0);
    req0(1'b1, 8'h01, 3'd3, 1'b0);
    tick();
    out_check("left3", 1'b1, 8'h08, 1'b0);

    // Backpressure, then reset mid-operation drops the held result.
    bus.oReady = 1'b0;
    req1(1'b1, 8'h3C, 3'd2, 1'b0);
    tick();
    out_check("pre_rst_hold", 1'b1, 8'h08, 1'b0);
    rst = 1'b1;
    #1;
    ready_check("mid_rst", 1'b0, 1'b0);
    tick();
    out_check("mid_rst", 1'b0, 8'h00, 1'b0);
    check("mid_rst_cnt0", 32'(bus.grantCnt0), 32'd0);
    check("mid_rst_cnt1", 32'(bus.grantCnt1), 32'd0);
    rst = 1'b0;
    bus.oReady = 1'b1;
    #1;
    ready_check("prio_reset", 1'b1, 1'b0);
    tick();
    out_check("post_rst", 1'b1, 8'h08, 1'b0);
    check("post_rst_cnt0", 32'(bus.grantCnt0), 32'd1);

    // Saturation of a 2-bit counter on the second instance.
    req0(1'b0, 8'h00, 3'd0, 1'b0);
    req1(1'b0, 8'h00, 3'd0, 1'b0);
    sat.req1Valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("sat_cnt1", 32'(sat.grantCnt1), (k < 3) ? 32'(k) : 32'd3);
    end
    check("sat_bits", 32'(sat.oBits), 32'h06);
    check("sat_src", 32'(sat.oSrc), 32'd1);
    check("sat_cnt0", 32'(sat.grantCnt0), 32'd0);
    sat.req1Valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
